// File: rtl/disp_scan.sv
// disp_scan: display back-end for the bit-serial display word.
//
// Receives a 4*NDIG-bit word one bit per cph2 strobe, LSB first. A word is
// framed by start=1 on bit 0. Each complete word is committed into a display
// buffer. A word cut short by a new start is dropped. The buffered digits are
// decoded to 7 segments and multiplex-scanned with a one-hot digit select.
//
// Parameters:
//   NDIG           digits per word (word = 4*NDIG bit times, at most 16 digits)
//   SCAN_DIV       cph2 strobes per digit scan slot (2..1024)
//   SEG_ACTIVE_LOW 1 inverts seg and dig_sel
//
// Optional feature macro: DISP_SCAN_LZB_EN (leading-zero blanking).
//
// Ports:
//   cfst       in   system clock, rising edge
//   pon        in   asynchronous active-high reset
//   cph2       in   bit-time strobe, one cfst cycle wide
//   disp_data  in   serial display bit, sampled when cph2=1
//   start      in   word-start marker, sampled when cph2=1
//   dig_en     in   display enable, 0 blanks dig_sel
//   seg        out  segments {g,f,e,d,c,b,a}, registered
//   dig_sel    out  one-hot digit select, registered
//   word_rdy   out  one-cycle pulse on word commit
//   frame_err  out  one-cycle pulse on word abort
//
// Handshake: there is no back-pressure. A bit is transferred on every cfst
// edge where cph2=1. word_rdy and frame_err are single-cycle pulses that
// follow that edge.
module disp_scan #(
    parameter int NDIG           = 14,
    parameter int SCAN_DIV       = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic            cfst,
    input  logic            pon,
    input  logic            cph2,
    input  logic            disp_data,
    input  logic            start,
    input  logic            dig_en,
    output logic [6:0]      seg,
    output logic [NDIG-1:0] dig_sel,
    output logic            word_rdy,
    output logic            frame_err
);

    localparam int         WBITS    = 4 * NDIG;
    localparam int         PW       = $clog2(SCAN_DIV);
    localparam int         IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [5:0] LAST_BIT = 6'(WBITS - 1);

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_t;

    rx_state_t rx_state, rx_state_next;

    logic [5:0]             bcnt, bcnt_next;
    logic [WBITS-1:0]       sr, sr_next;
    logic                   commit, abort;
    logic [NDIG-1:0][3:0]   disp_buf;
    logic [PW-1:0]          presc;
    logic [IW-1:0]          idx;
    logic                   digit_blank;
    logic [6:0]             seg_raw;
    logic [NDIG-1:0]        sel_raw;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h40;  // minus
            4'hB:    s = 7'h79;  // 'E'
            4'hC:    s = 7'h50;  // 'r'
            4'hD:    s = 7'h5C;  // 'o'
            default: s = 7'h00;  // E, F: blank
        endcase
        return s;
    endfunction

    // ---------------- receiver FSM ----------------
    always_ff @(posedge cfst or posedge pon) begin
        if (pon) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state;
        bcnt_next     = bcnt;
        sr_next       = sr;
        commit        = 1'b0;
        abort         = 1'b0;
        if (cph2) begin
            case (rx_state)
                RX_IDLE: begin
                    if (start) begin
                        sr_next       = '0;
                        sr_next[0]    = disp_data;
                        bcnt_next     = 6'd1;
                        rx_state_next = RX_SHIFT;
                    end
                end
                RX_SHIFT: begin
                    if (start) begin
                        // A new start wins even on the final bit. The partial
                        // word is dropped and this bit becomes bit 0.
                        abort      = 1'b1;
                        sr_next    = '0;
                        sr_next[0] = disp_data;
                        bcnt_next  = 6'd1;
                    end else begin
                        sr_next[bcnt] = disp_data;
                        if (bcnt == LAST_BIT) begin
                            commit        = 1'b1;
                            bcnt_next     = 6'd0;
                            rx_state_next = RX_IDLE;
                        end else begin
                            bcnt_next = bcnt + 6'd1;
                        end
                    end
                end
                default: rx_state_next = RX_IDLE;
            endcase
        end
    end

    // The buffer loads the word including the bit captured on this edge.
    always_ff @(posedge cfst or posedge pon) begin
        if (pon) begin
            bcnt      <= '0;
            sr        <= '0;
            disp_buf  <= {NDIG{4'hF}};
            word_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            bcnt      <= bcnt_next;
            sr        <= sr_next;
            word_rdy  <= commit;
            frame_err <= abort;
            if (commit) disp_buf <= sr_next;
        end
    end

    // ---------------- leading-zero blanking ----------------
`ifdef DISP_SCAN_LZB_EN
    logic [NDIG-1:0] blank_mask, blank_next;

    // Walk from the top digit down. Zeros stay blank while only zeros or
    // blank codes have been seen. Digit 0 is always shown.
    always_comb begin
        logic       lead;
        logic [3:0] code;
        blank_next = '0;
        lead       = 1'b1;
        code       = 4'h0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            code = sr_next[4*i +: 4];
            if (lead && code == 4'h0) blank_next[i] = 1'b1;
            else if (code < 4'hE)     lead          = 1'b0;
        end
    end

    always_ff @(posedge cfst or posedge pon) begin
        if (pon)         blank_mask <= '0;
        else if (commit) blank_mask <= blank_next;
    end

    assign digit_blank = blank_mask[idx];
`else
    assign digit_blank = 1'b0;
`endif

    // ---------------- scan ----------------
    always_ff @(posedge cfst or posedge pon) begin
        if (pon) begin
            presc <= '0;
            idx   <= '0;
        end else if (cph2) begin
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc <= '0;
                idx   <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // The slot with presc==0 is dark. It hides segment changes while the
    // select moves to the next digit.
    always_comb begin
        seg_raw = digit_blank ? 7'h00 : seg_decode(disp_buf[idx]);
        sel_raw = '0;
        if (presc != '0 && dig_en) sel_raw[idx] = 1'b1;
    end

    always_ff @(posedge cfst or posedge pon) begin
        if (pon) begin
            seg     <= {7{SEG_ACTIVE_LOW}};
            dig_sel <= {NDIG{SEG_ACTIVE_LOW}};
        end else begin
            seg     <= seg_raw ^ {7{SEG_ACTIVE_LOW}};
            dig_sel <= sel_raw ^ {NDIG{SEG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
module tb_disp_scan;

  localparam int NDIG = 14;
  localparam int SD   = 8;
  localparam int WB   = 4 * NDIG;

  logic            cfst = 1'b0;
  logic            pon;
  logic            cph2;
  logic            disp_data;
  logic            start;
  logic            dig_en;
  logic [6:0]      seg;
  logic [NDIG-1:0] dig_sel;
  logic            word_rdy;
  logic            frame_err;

  disp_scan #(.NDIG(NDIG), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0)) dut (
    .cfst(cfst), .pon(pon), .cph2(cph2), .disp_data(disp_data), .start(start),
    .dig_en(dig_en), .seg(seg), .dig_sel(dig_sel), .word_rdy(word_rdy),
    .frame_err(frame_err)
  );

  // ---------------- clock / reset ----------------
  always #5 cfst = ~cfst;

  // ---------------- reference model state ----------------
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h79, 7'h50, 7'h5C, 7'h00, 7'h00};
  logic [3:0] exp_buf [NDIG];
  logic       cur_q[$];
  bit         in_word;
  int         n_strobes;
  int         rdy_seen;
  int         ferr_seen;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDIG; i++) exp_buf[i] = 4'hF;
    cur_q.delete();
    in_word   = 1'b0;
    n_strobes = 0;
  endtask

  function automatic int cur_idx();
    return (n_strobes / SD) % NDIG;
  endfunction

  function automatic int cur_presc();
    return n_strobes % SD;
  endfunction

  function automatic logic [6:0] exp_seg_f();
    int         k;
    logic [3:0] code;
    bit         blank;
    k     = cur_idx();
    code  = exp_buf[k];
    blank = 1'b0;
`ifdef DISP_SCAN_LZB_EN
    if (k > 0 && code == 4'h0) begin
      blank = 1'b1;
      for (int j = k + 1; j < NDIG; j++)
        if (exp_buf[j] != 4'h0 && exp_buf[j] < 4'hE) blank = 1'b0;
    end
`endif
    return blank ? 7'h00 : seg_tab[code];
  endfunction

  function automatic logic [NDIG-1:0] exp_sel_f();
    logic [NDIG-1:0] v;
    v = '0;
    if (cur_presc() != 0 && dig_en) v[cur_idx()] = 1'b1;
    return v;
  endfunction

  // ---------------- driver ----------------
  // One strobe, followed by 'gap' idle cycles. The model is advanced first.
  // word_rdy and frame_err are sampled just after the strobe edge. seg and
  // dig_sel are sampled after the idle edges, once they reflect the new state.
  task automatic strobe(input logic d, input logic s, input int gap);
    logic e_rdy;
    logic e_ferr;
    e_rdy  = 1'b0;
    e_ferr = 1'b0;
    if (s) begin
      e_ferr = in_word;
      cur_q.delete();
      cur_q.push_back(d);
      in_word = 1'b1;
    end else if (in_word) begin
      cur_q.push_back(d);
      if (cur_q.size() == WB) begin
        for (int i = 0; i < NDIG; i++)
          exp_buf[i] = {cur_q[4*i+3], cur_q[4*i+2], cur_q[4*i+1], cur_q[4*i]};
        e_rdy   = 1'b1;
        in_word = 1'b0;
        cur_q.delete();
      end
    end
    n_strobes++;
    disp_data = d;
    start     = s;
    cph2      = 1'b1;
    @(posedge cfst); #1;
    cph2 = 1'b0;
    check("word_rdy", word_rdy, e_rdy);
    check("frame_err", frame_err, e_ferr);
    if (word_rdy)  rdy_seen++;
    if (frame_err) ferr_seen++;
    repeat (gap) @(posedge cfst);
    #1;
    check("pulse_width", {word_rdy, frame_err}, 2'b00);
    check("seg", seg, exp_seg_f());
    check("dig_sel", dig_sel, exp_sel_f());
  endtask

  task automatic send_bits(input logic [WB-1:0] w, input int n);
    for (int j = 0; j < n; j++) strobe(w[j], j == 0, $urandom_range(1, 2));
  endtask

  task automatic send_word(input logic [WB-1:0] w);
    int r0;
    r0 = rdy_seen;
    send_bits(w, WB);
    check("commit_once", rdy_seen - r0, 1);
  endtask

  // Step strobes until the model is at the slot and phase asked for. The
  // bound depends only on the model, so this always ends.
  task automatic advance_to(input int slot, input bit ghost);
    for (int k = 0; k < 2 * NDIG * SD; k++) begin
      if (cur_idx() == slot && (ghost ? cur_presc() == 0 : cur_presc() != 0)) break;
      strobe(1'b0, 1'b0, 1);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [WB-1:0]   word;
    int              slot;
    bit              ghost;
    logic [6:0]      seg;
    logic [NDIG-1:0] sel;
  } vec_t;

  localparam logic [WB-1:0] W1 = 56'hDCBA0987654321;  // digits 0..13 = 1..9,0,A..D
  localparam logic [WB-1:0] WF = {NDIG{4'hF}};
  localparam logic [WB-1:0] W4 = 56'h00000000000005;
  localparam logic [WB-1:0] W6 = 56'h00E03000000000;

  vec_t tv [14];

  initial begin
    logic [6:0]    lz;
    logic [WB-1:0] w;
    int            f0;
    int            r0;
    int            nz;
    int            mode;

`ifdef DISP_SCAN_LZB_EN
    lz = 7'h00;
`else
    lz = 7'h3F;
`endif
    tv[0]  = '{W1, 3,  1'b0, 7'h66, 14'h0008};
    tv[1]  = '{W1, 10, 1'b0, 7'h40, 14'h0400};
    tv[2]  = '{W1, 0,  1'b0, 7'h06, 14'h0001};
    tv[3]  = '{W1, 13, 1'b0, 7'h5C, 14'h2000};
    tv[4]  = '{W1, 11, 1'b0, 7'h79, 14'h0800};
    tv[5]  = '{W1, 12, 1'b0, 7'h50, 14'h1000};
    tv[6]  = '{W1, 5,  1'b1, 7'h7D, 14'h0000};
    tv[7]  = '{WF, 5,  1'b0, 7'h00, 14'h0020};
    tv[8]  = '{W4, 0,  1'b0, 7'h6D, 14'h0001};
    tv[9]  = '{W4, 1,  1'b0, lz,    14'h0002};
    tv[10] = '{W4, 13, 1'b0, lz,    14'h2000};
    tv[11] = '{W6, 10, 1'b0, lz,    14'h0400};
    tv[12] = '{W6, 4,  1'b0, 7'h3F, 14'h0010};
    tv[13] = '{W6, 9,  1'b0, 7'h4F, 14'h0200};

    pon = 1'b1; cph2 = 1'b0; disp_data = 1'b0; start = 1'b0; dig_en = 1'b0;
    rdy_seen = 0; ferr_seen = 0;
    model_reset();
    repeat (3) @(posedge cfst);
    #1;
    check("rst_seg", seg, 7'h00);
    check("rst_dig_sel", dig_sel, '0);
    check("rst_word_rdy", word_rdy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    pon = 1'b0;
    @(posedge cfst); #1;

    // idle strobes with start=0 are ignored
    for (int i = 0; i < 10; i++) strobe($urandom_range(0, 1), 1'b0, 1);
    check("idle_no_rdy", rdy_seen, 0);
    check("idle_no_ferr", ferr_seen, 0);
    check("idle_seg", seg, 7'h00);
    check("idle_dig_sel", dig_sel, '0);

    // table-driven decode / slot checks
    dig_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send_word(tv[i].word);
      advance_to(tv[i].slot, tv[i].ghost);
      check($sformatf("tv%0d_seg", i), seg, tv[i].seg);
      check($sformatf("tv%0d_sel", i), dig_sel, tv[i].sel);
    end

    // abort at bit 30, then a full word
    f0 = ferr_seen; r0 = rdy_seen;
    send_bits(W6, 30);
    send_word(W1);
    check("abort30_ferr", ferr_seen - f0, 1);
    check("abort30_rdy", rdy_seen - r0, 1);

    // abort on the final bit position
    f0 = ferr_seen; r0 = rdy_seen;
    send_bits(W4, 55);
    send_word(W6);
    check("abort55_ferr", ferr_seen - f0, 1);
    check("abort55_rdy", rdy_seen - r0, 1);

    // dig_en low for a full scan cycle
    dig_en = 1'b0;
    nz = 0;
    for (int k = 0; k < NDIG * SD; k++) begin
      strobe($urandom_range(0, 1), 1'b0, 1);
      if (dig_sel != '0) nz++;
    end
    check("dig_en_blank", nz, 0);
    dig_en = 1'b1;
    for (int k = 0; k < 2 * SD; k++) strobe(1'b0, 1'b0, 1);

    // reset mid-word at bit 20
    send_bits(W1, 20);
    pon = 1'b1;
    #2;
    check("async_rst_seg", seg, 7'h00);
    check("async_rst_dig_sel", dig_sel, '0);
    check("async_rst_flags", {word_rdy, frame_err}, 2'b00);
    model_reset();
    @(posedge cfst); #1;
    pon = 1'b0;
    @(posedge cfst); #1;
    f0 = ferr_seen;
    strobe(1'b0, 1'b0, 1);
    check("post_rst_blank", seg, 7'h00);
    send_word(W4);
    check("post_rst_no_ferr", ferr_seen - f0, 0);

    // randomized traffic against the model
    for (int it = 0; it < 25; it++) begin
      w      = WB'({$urandom(), $urandom()});
      mode   = $urandom_range(0, 3);
      dig_en = $urandom_range(0, 1);
      if (mode == 0) send_bits(w, $urandom_range(1, WB - 1));
      else           send_bits(w, WB);
      for (int k = 0; k < $urandom_range(0, 10); k++)
        strobe($urandom_range(0, 1), 1'b0, $urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
